// File: rtl/j11bus.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : j11bus                                                   |
// | Description : J11 bus-request responder: main memory, DL11 console,    |
// |               GP register and non-existent-memory timeout.             |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module j11bus #(
    parameter int          MEMAW  = 17,
    parameter int          NXMCYC = 16,
    parameter logic [15:0] GPVAL  = 16'o000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             busreq,
    input  logic             buswr,
    input  logic             busgp,
    input  logic [21:0]      busaddr,
    input  logic [15:0]      buswdata,
    output logic             busack,
    output logic [15:0]      busrdata,
    output logic             memreq,
    output logic             memwr,
    output logic [MEMAW-1:0] memaddr,
    output logic [15:0]      memwdata,
    input  logic             memack,
    input  logic [15:0]      memrdata,
    input  logic [7:0]       rxdata,
    input  logic             rxvalid,
    output logic             rxready,
    output logic [7:0]       txdata,
    output logic             txvalid,
    input  logic             txready,
    output logic             rxirq,
    output logic             txirq,
    output logic             nxm
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_MEMWAIT = 2'd1;
    localparam logic [1:0] c_ST_NXMWAIT = 2'd2;
    localparam logic [1:0] c_ST_ACK     = 2'd3;

    localparam int                 c_NXM_W    = $clog2(NXMCYC + 1);
    localparam logic [c_NXM_W-1:0] c_NXM_LOAD = c_NXM_W'(NXMCYC - 1);
    localparam logic [c_NXM_W-1:0] c_NXM_ONE  = c_NXM_W'(1);

    localparam logic [21:0] c_RCSR = 22'o17777560;
    localparam logic [21:0] c_RBUF = 22'o17777562;
    localparam logic [21:0] c_XCSR = 22'o17777564;
    localparam logic [21:0] c_XBUF = 22'o17777566;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_NXM_W-1:0] r_nxm_cnt;
    logic               r_req_wr;
    logic [15:0]        r_busrdata;
    logic               r_memreq;
    logic               r_memwr;
    logic [MEMAW-1:0]   r_memaddr;
    logic [15:0]        r_memwdata;
    logic               r_nxm;

    logic               r_rx_done;
    logic               r_rx_ie;
    logic [7:0]         r_rxbuf;
    logic               r_tx_ready;
    logic               r_tx_ie;
    logic               r_txvalid;
    logic [7:0]         r_txdata;

    logic [21:0]        w_word;
    logic               w_is_mem;
    logic               w_is_con;
    logic               w_capture;
    logic               w_con_acc;
    logic [15:0]        w_con_rdata;
    logic               w_unused;

    assign w_word   = {busaddr[21:1], 1'b0};
    assign w_unused = busaddr[0];

    generate
        if (MEMAW + 1 >= 22) begin : g_mem_full
            assign w_is_mem = 1'b1;
        end else begin : g_mem_part
            assign w_is_mem = (busaddr[21:MEMAW+1] == '0);
        end
    endgenerate

    assign w_is_con  = (w_word == c_RCSR) || (w_word == c_RBUF) ||
                       (w_word == c_XCSR) || (w_word == c_XBUF);
    assign w_capture = (r_state == c_ST_IDLE) && busreq;
    // A console access only happens when neither GP nor memory claims the cycle.
    assign w_con_acc = w_capture && !busgp && !w_is_mem && w_is_con;

    always_comb begin
        w_con_rdata = 16'h0000;
        case (w_word)
            c_RCSR:  w_con_rdata = {8'h00, r_rx_done, r_rx_ie, 6'b000000};
            c_RBUF:  w_con_rdata = {8'h00, r_rxbuf};
            c_XCSR:  w_con_rdata = {8'h00, r_tx_ready, r_tx_ie, 6'b000000};
            default: w_con_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (busreq) begin
                    if (busgp)         w_state_nxt = c_ST_ACK;
                    else if (w_is_mem) w_state_nxt = c_ST_MEMWAIT;
                    else if (w_is_con) w_state_nxt = c_ST_ACK;
                    else               w_state_nxt = c_ST_NXMWAIT;
                end
            end
            c_ST_MEMWAIT: if (memack) w_state_nxt = c_ST_ACK;
            c_ST_NXMWAIT: if (r_nxm_cnt == '0) w_state_nxt = c_ST_ACK;
            c_ST_ACK:     w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busrdata <= 16'h0000;
            r_memreq   <= 1'b0;
            r_memwr    <= 1'b0;
            r_memaddr  <= '0;
            r_memwdata <= 16'h0000;
            r_nxm      <= 1'b0;
            r_nxm_cnt  <= '0;
            r_req_wr   <= 1'b0;
        end else begin
            r_memreq <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (busreq) begin
                        r_req_wr <= buswr;
                        if (busgp) begin
                            if (!buswr) r_busrdata <= GPVAL;
                        end else if (w_is_mem) begin
                            r_memreq   <= 1'b1;
                            r_memwr    <= buswr;
                            r_memaddr  <= busaddr[MEMAW:1];
                            r_memwdata <= buswdata;
                        end else if (w_is_con) begin
                            if (!buswr) r_busrdata <= w_con_rdata;
                        end else begin
                            r_nxm     <= 1'b1;
                            r_nxm_cnt <= c_NXM_LOAD;
                        end
                    end
                end
                c_ST_MEMWAIT: begin
                    if (memack && !r_memwr) r_busrdata <= memrdata;
                end
                c_ST_NXMWAIT: begin
                    // Read data is cleared only at completion so it holds until the ack.
                    if (r_nxm_cnt != '0)  r_nxm_cnt  <= r_nxm_cnt - c_NXM_ONE;
                    else if (!r_req_wr)   r_busrdata <= 16'h0000;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_done  <= 1'b0;
            r_rx_ie    <= 1'b0;
            r_rxbuf    <= 8'h00;
            r_tx_ready <= 1'b1;
            r_tx_ie    <= 1'b0;
            r_txvalid  <= 1'b0;
            r_txdata   <= 8'h00;
        end else begin
            // An incoming byte beats a simultaneous RBUF read clearing DONE.
            if (rxvalid && !r_rx_done) begin
                r_rxbuf   <= rxdata;
                r_rx_done <= 1'b1;
            end else if (w_con_acc && !buswr && (w_word == c_RBUF)) begin
                r_rx_done <= 1'b0;
            end

            if (w_con_acc && buswr && (w_word == c_RCSR)) r_rx_ie <= buswdata[6];
            if (w_con_acc && buswr && (w_word == c_XCSR)) r_tx_ie <= buswdata[6];

            if (w_con_acc && buswr && (w_word == c_XBUF) && r_tx_ready) begin
                r_txdata   <= buswdata[7:0];
                r_txvalid  <= 1'b1;
                r_tx_ready <= 1'b0;
            end else if (r_txvalid && txready) begin
                r_txvalid  <= 1'b0;
                r_tx_ready <= 1'b1;
            end
        end
    end

    assign busack   = (r_state == c_ST_ACK);
    assign busrdata = r_busrdata;
    assign memreq   = r_memreq;
    assign memwr    = r_memwr;
    assign memaddr  = r_memaddr;
    assign memwdata = r_memwdata;
    assign nxm      = r_nxm;
    assign rxready  = !r_rx_done;
    assign txdata   = r_txdata;
    assign txvalid  = r_txvalid;
    assign rxirq    = r_rx_ie & r_rx_done;
    assign txirq    = r_tx_ie & r_tx_ready;

endmodule
`default_nettype wire
